// File: rtl/core_types_pkg.sv
// Shared types for the multi-cycle RV32M sequencer: op encoding, FSM states,
// iteration count and small signedness helpers.
package core_types_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } muldiv_state_t;

   typedef enum logic {
      STEP_MUL = 1'b0,
      STEP_DIV = 1'b1
   } step_mode_t;

   localparam int MULDIV_ITER = 32;

   function automatic logic op_is_div(muldiv_op_t o);
      return o inside {DIV, DIVU, REM, REMU};
   endfunction

   // MUL is treated as signed x signed; its low half is identical either way.
   function automatic logic op_a_signed(muldiv_op_t o);
      return o inside {MUL, MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic op_b_signed(muldiv_op_t o);
      return o inside {MUL, MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared shift-add multiply / restoring
// divide loop. acc = {high half, low half}; operand = multiplicand or divisor.
module muldiv_step
   import core_types_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   input  step_mode_t        mode,
   output logic [2*XLEN-1:0] acc_next,
   output logic              borrow
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   logic [XLEN-1:0] rem_next;
   logic          rem_unused;

   always_comb begin
      sum        = '0;
      shifted    = '0;
      diff       = '0;
      rem_next   = '0;
      rem_unused = 1'b0;
      borrow     = 1'b0;
      acc_next   = '0;
      if (mode == STEP_MUL) begin
         // The carry out of the high half becomes the new MSB after the shift.
         sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
         acc_next = {sum, acc[XLEN-1:1]};
      end else begin
         shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
         borrow   = shifted < {1'b0, operand};
         diff     = shifted - {1'b0, operand};
         {rem_unused, rem_next} = borrow ? shifted : diff;
         // The quotient bit slot is left zero; the caller fills it from borrow.
         acc_next = {rem_next, acc[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: accepts one op, iterates 32
// times through muldiv_step, applies sign fix-up and holds the result.
module muldiv_seq
   import core_types_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  muldiv_op_t      op,
   input  logic [XLEN-1:0] rs1F,
   input  logic [XLEN-1:0] rs2F,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] result,
   output logic            busy,
   output logic            stall
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITER - 1);
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t     state, state_d;
   logic [CNT_W-1:0]  cnt;
   muldiv_op_t        op_q;
   logic [2*XLEN-1:0] acc, step_acc, acc_calc, prod;
   logic [XLEN-1:0]   opnd, result_q, quo, rem, fix_val;
   logic [XLEN-1:0]   mag_a, mag_b, special_val;
   logic              neg_main, neg_rem, sign_a, sign_b;
   logic              accept, special_hit, step_borrow;
   step_mode_t        step_mode;

   // Valid/ready: a transfer happens on a rising edge where valid and ready
   // are both high; the sender holds its payload until then. flush cancels
   // any transfer in its cycle, and ready/valid are forced low during rst.
   assign req_ready  = (state == IDLE) && !rst;
   assign resp_valid = (state == DONE) && !rst;
   assign busy       = (state != IDLE) && !rst;
   assign stall      = busy && !(resp_valid && resp_ready);
   assign result     = result_q;
   assign accept     = req_valid && req_ready && !flush;

   assign sign_a = op_a_signed(op) && rs1F[XLEN-1];
   assign sign_b = op_b_signed(op) && rs2F[XLEN-1];
   assign mag_a  = sign_a ? -rs1F : rs1F;
   assign mag_b  = sign_b ? -rs2F : rs2F;

   always_comb begin
      special_hit = 1'b0;
      special_val = '0;
      if (op_is_div(op) && rs2F == '0) begin
         special_hit = 1'b1;
         special_val = (op == DIV || op == DIVU) ? '1 : rs1F;
      end else if ((op == DIV || op == REM) && rs1F == INT_MIN && rs2F == '1) begin
         special_hit = 1'b1;
         special_val = (op == DIV) ? INT_MIN : '0;
      end
   end

   assign step_mode = op_is_div(op_q) ? STEP_DIV : STEP_MUL;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .acc      (acc),
      .operand  (opnd),
      .mode     (step_mode),
      .acc_next (step_acc),
      .borrow   (step_borrow)
   );

   assign acc_calc = (step_mode == STEP_DIV) ? {step_acc[2*XLEN-1:1], ~step_borrow}
                                             : step_acc;

   always_comb begin
      prod    = neg_main ? -acc : acc;
      quo     = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem     = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      fix_val = rem;
      case (op_q)
         MUL:                 fix_val = prod[XLEN-1:0];
         MULH, MULHSU, MULHU: fix_val = prod[2*XLEN-1:XLEN];
         DIV, DIVU:           fix_val = quo;
         default:             fix_val = rem;
      endcase
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept) state_d = special_hit ? DONE : CALC;
         CALC:    if (cnt == CNT_LAST) state_d = FIXUP;
         FIXUP:   state_d = DONE;
         DONE:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         op_q     <= MUL;
         acc      <= '0;
         opnd     <= '0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               // acc low half starts as multiplier (MUL*) or dividend (DIV*).
               op_q     <= op;
               cnt      <= '0;
               neg_main <= sign_a ^ sign_b;
               neg_rem  <= sign_a;
               opnd     <= op_is_div(op) ? mag_b : mag_a;
               acc      <= {{XLEN{1'b0}}, (op_is_div(op) ? mag_a : mag_b)};
               if (special_hit) result_q <= special_val;
            end
            CALC: begin
               acc <= acc_calc;
               cnt <= cnt + CNT_W'(1);
            end
            FIXUP:   result_q <= fix_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed RV32M cases, timing, flush/reset abort,
// response back-pressure and randomized ops against an arithmetic model.
module tb_muldiv_seq;
   import core_types_pkg::*;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst, req_valid, flush, resp_ready;
   muldiv_op_t  op;
   logic [31:0] rs1F, rs2F;
   logic        req_ready, resp_valid, busy, stall;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   muldiv_seq #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .op         (op),
      .rs1F       (rs1F),
      .rs2F       (rs2F),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .result     (result),
      .busy       (busy),
      .stall      (stall)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_model(muldiv_op_t o, logic [31:0] a, logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = '0;
      case (o)
         MUL, MULH: p = 64'(sa * sb);
         MULHSU:    p = 64'(sa * ub);
         MULHU:     p = {32'h0, a} * {32'h0, b};
         DIV:       if (b == 0) p = '1; else p = 64'(sa / sb);
         DIVU:      if (b == 0) p = '1; else p = 64'(ua / ub);
         REM:       if (b == 0) p = 64'(ua); else p = 64'(sa % sb);
         default:   if (b == 0) p = 64'(ua); else p = 64'(ua % ub);
      endcase
      if (o == MULH || o == MULHSU || o == MULHU) return p[63:32];
      return p[31:0];
   endfunction

   function automatic int exp_latency(muldiv_op_t o, logic [31:0] a, logic [31:0] b);
      logic is_div, ovf;
      is_div = (o == DIV || o == DIVU || o == REM || o == REMU);
      ovf    = (o == DIV || o == REM) && a == INT_MIN && b == 32'hFFFF_FFFF;
      return (is_div && (b == 0 || ovf)) ? 1 : 34;
   endfunction

   task automatic apply_reset();
      rst = 1'b1; req_valid = 1'b1; flush = 1'b0; resp_ready = 1'b0;
      op = MUL; rs1F = 32'd3; rs2F = 32'd4;
      repeat (3) tick();
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: rr=%b rv=%b busy=%b stall=%b want all 0",
                  req_ready, resp_valid, busy, stall);
      end
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (result !== 32'h0 || req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: result=%h rr=%b busy=%b rv=%b want 0/1/0/0",
                  result, req_ready, busy, resp_valid);
      end
   endtask

   // One transaction; hold = cycles resp_ready stays low once DONE is reached.
   task automatic do_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string name);
      int lat;
      int want_lat;
      logic stall_bad, hold_bad;
      logic [31:0] exp_r;
      exp_q.push_back(ref_model(o, a, b));
      want_lat = exp_latency(o, a, b);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready_before_accept: got %b want 1", name, req_ready);
      end
      op = o; rs1F = a; rs2F = b; req_valid = 1'b1; resp_ready = (hold == 0);
      tick();
      req_valid = 1'b0;
      op = muldiv_op_t'(3'($urandom_range(0, 7)));
      rs1F = $urandom; rs2F = $urandom;
      lat = 1; stall_bad = 1'b0;
      while (resp_valid !== 1'b1 && lat < 100) begin
         if (stall !== 1'b1) stall_bad = 1'b1;
         tick();
         lat++;
      end
      exp_r = exp_q.pop_front();
      checks++;
      if (lat != want_lat) begin
         failures++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
         if (lat >= 100) begin
            apply_reset();
            return;
         end
      end
      checks++;
      if (stall_bad) begin
         failures++;
         $display("FAIL %s stall_while_busy: got 0 want 1", name);
      end
      checks++;
      if (result !== exp_r || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s result: got %h rr=%b want %h rr=0", name, result, req_ready, exp_r);
      end
      if (hold > 0) begin
         hold_bad = 1'b0;
         for (int i = 0; i < hold; i++) begin
            if (resp_valid !== 1'b1 || result !== exp_r || stall !== 1'b1) hold_bad = 1'b1;
            tick();
         end
         checks++;
         if (hold_bad) begin
            failures++;
            $display("FAIL %s hold_stable: rv=%b result=%h stall=%b want 1/%h/1",
                     name, resp_valid, result, stall, exp_r);
         end
      end
      resp_ready = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || resp_valid !== 1'b1 || result !== exp_r) begin
         failures++;
         $display("FAIL %s handshake: stall=%b rv=%b result=%h want 0/1/%h",
                  name, stall, resp_valid, result, exp_r);
      end
      tick();
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s after_handshake: rv=%b busy=%b rr=%b want 0/0/1",
                  name, resp_valid, busy, req_ready);
      end
   endtask

   task automatic test_mul_timing();
      do_op(MUL, 32'd7, 32'hFFFF_FFFD, 0, "mul_7_neg3");
   endtask

   task automatic test_directed();
      do_op(MULH,   INT_MIN,        INT_MIN,        0, "mulh_min");
      do_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, "mulhu_max");
      do_op(MULHSU, 32'hFFFF_FFFF,  32'd2,          0, "mulhsu");
      do_op(DIV,    32'hFFFF_FFF9,  32'd2,          0, "div_neg7_2");
      do_op(REM,    32'hFFFF_FFF9,  32'd2,          0, "rem_neg7_2");
      do_op(DIVU,   32'd100,        32'd7,          0, "divu_100_7");
      do_op(REMU,   32'd100,        32'd7,          0, "remu_100_7");
   endtask

   task automatic test_special();
      do_op(DIVU, 32'd5,   32'd0,          0, "divu_by0");
      do_op(REM,  32'd5,   32'd0,          0, "rem_by0");
      do_op(DIV,  INT_MIN, 32'hFFFF_FFFF,  0, "div_ovf");
      do_op(REM,  INT_MIN, 32'hFFFF_FFFF,  0, "rem_ovf");
   endtask

   task automatic test_abort(input logic use_rst, input string name);
      logic seen;
      op = MUL; rs1F = $urandom; rs2F = $urandom; req_valid = 1'b1; resp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (10) tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL %s busy_in_calc: got %b want 1", name, busy);
      end
      if (use_rst) rst = 1'b1;
      else         flush = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s idle_after: busy=%b rr=%b rv=%b want 0/1/0",
                  name, busy, req_ready, resp_valid);
      end
      if (use_rst) begin
         checks++;
         if (result !== 32'h0) begin
            failures++;
            $display("FAIL %s result_cleared: got %h want 0", name, result);
         end
      end
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (resp_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL %s no_response: got resp_valid=1 want never", name);
      end
   endtask

   task automatic test_flush_idle();
      logic seen;
      op = DIVU; rs1F = 32'd9; rs2F = 32'd0; req_valid = 1'b1; flush = 1'b1;
      tick();
      req_valid = 1'b0; flush = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         if (busy !== 1'b0 || resp_valid !== 1'b0) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL flush_idle_ignored: got busy/resp activity want none");
      end
   endtask

   task automatic test_hold();
      do_op(DIV, 32'd1000, 32'hFFFF_FFFD, 5, "hold_div");
      do_op(DIVU, 32'd5, 32'd0, 5, "hold_special");
   endtask

   task automatic test_back_to_back();
      do_op(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 0, "b2b_0");
      do_op(REMU,  32'hDEAD_BEEF, 32'h0000_1234, 0, "b2b_1");
      do_op(MUL,   32'h8000_0001, 32'h7FFF_FFFF, 0, "b2b_2");
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return INT_MIN;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      muldiv_op_t o;
      for (int i = 0; i < 40; i++) begin
         o = muldiv_op_t'(3'($urandom_range(0, 7)));
         do_op(o, pick_operand(), pick_operand(), $urandom_range(0, 2) == 0 ? 2 : 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_mul_timing();
      test_directed();
      test_special();
      test_abort(1'b0, "flush_calc");
      test_abort(1'b1, "rst_calc");
      test_flush_idle();
      test_hold();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
